if_fetch_ctrl: RTL and testbench

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/if_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_if_fetch_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues one bus read at a time, buffers the returned word for ID,
// and drops data belonging to a fetch that was redirected by a flush while in flight.
module if_fetch_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_exp,
  input  logic        stall,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitData, StHold} state_e;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
      buf_q     <= NOP_INST;
      pend_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    buf_d     = buf_q;
    pend_d    = pend_q;
    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (pc_exp) begin
          state_d = StHold;
          buf_d   = NOP_INST;
        end else if (inst_addr_ok) begin
          // A flush in the accept cycle means the returning word is already stale.
          state_d   = StWaitData;
          pend_d    = pc;
          discard_d = flush;
        end
      end
      StWaitData: begin
        if (inst_data_ok) begin
          if (discard_q || flush) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            buf_d   = inst_rdata;
            state_d = StHold;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      StHold: begin
        if (!stall || flush) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced while rst is high so they are defined before the first reset edge.
  always_comb begin
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    inst_valid  = 1'b0;
    fetch_stall = 1'b1;
    inst_out    = buf_q;
    if (rst) begin
      inst_out = NOP_INST;
    end else begin
      case (state_q)
        StReq: begin
          inst_req  = ~pc_exp;
          inst_addr = pc;
        end
        StWaitData: inst_addr = pend_q;
        StHold: begin
          inst_valid  = 1'b1;
          fetch_stall = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: scenario tasks with a queue of expected delivered words.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0bad_0013;

  logic        clk = 1'b0;
  logic        rst, pc_exp, stall, flush;
  logic [31:0] pc, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        inst_req, inst_valid, fetch_stall;
  logic [31:0] inst_addr, inst_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  if_fetch_ctrl #(.NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_exp       (pc_exp),
    .stall        (stall),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst_valid   (inst_valid),
    .inst_out     (inst_out),
    .fetch_stall  (fetch_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'h0; pc_exp = 1'b0; stall = 1'b0; flush = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    tick();
    tick();
    n_tests++;
    if ({inst_req, inst_valid, fetch_stall} !== 3'b001) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 001", {inst_req, inst_valid, fetch_stall});
    end
    n_tests++;
    if (inst_addr !== 32'h0 || inst_out !== NOP) begin
      n_fail++; $display("FAIL reset_data: got addr %h out %h expected 0 %h", inst_addr, inst_out, NOP);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (inst_req !== 1'b0 || fetch_stall !== 1'b1) begin
      n_fail++; $display("FAIL idle_first: got req %b fs %b expected 0 1", inst_req, fetch_stall);
    end
    tick();
  endtask

  task automatic test_normal();
    logic [31:0] e;
    pc = 32'hbfc0_0000; inst_addr_ok = 1'b1;
    #1;
    n_tests++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000) begin
      n_fail++; $display("FAIL normal_req: got req %b addr %h expected 1 bfc00000", inst_req, inst_addr);
    end
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001; pc = 32'h0;
    exp_q.push_back(32'h2408_0001);
    #1;
    n_tests++;
    if (inst_req !== 1'b0 || inst_addr !== 32'hbfc0_0000 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL normal_wait: got req %b addr %h valid %b expected 0 bfc00000 0",
                         inst_req, inst_addr, inst_valid);
    end
    tick();
    inst_data_ok = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b1 || fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL normal_hold: got valid %b fs %b expected 1 0", inst_valid, fetch_stall);
    end
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL normal_sb: got empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      if (inst_out !== e) begin
        n_fail++; $display("FAIL normal_data: got %h expected %h", inst_out, e);
      end
    end
    tick();
    n_tests++;
    if (inst_valid !== 1'b0 || inst_req !== 1'b1) begin
      n_fail++; $display("FAIL normal_back: got valid %b req %b expected 0 1", inst_valid, inst_req);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      pc = 32'hbfc0_0004 + 32'(i) * 32'h100; inst_addr_ok = 1'b0;
      #1;
      n_tests++;
      if (inst_req !== 1'b1 || inst_addr !== pc || fetch_stall !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: got req %b addr %h fs %b expected 1 %h 1",
                           inst_req, inst_addr, fetch_stall, pc);
      end
      tick();
    end
    pc = 32'hbfc0_0380; inst_addr_ok = 1'b1;
    tick();
    pc = 32'h1111_1110; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8c08_0004;
    exp_q.push_back(32'h8c08_0004);
    #1;
    n_tests++;
    if (inst_addr !== 32'hbfc0_0380 || fetch_stall !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept: got addr %h fs %b expected bfc00380 1", inst_addr, fetch_stall);
    end
    tick();
    inst_data_ok = 1'b0;
    #1;
    n_tests++;
    if (exp_q.size() == 0 || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_sb: got valid %b size %0d expected 1 1", inst_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (inst_out !== e) begin
        n_fail++; $display("FAIL bp_data: got %h expected %h", inst_out, e);
      end
    end
    tick();
  endtask

  task automatic test_flush_inflight();
    pc = 32'hbfc0_0400; inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; pc = 32'h8000_0180;
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678;
    tick();
    inst_data_ok = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h8000_0180) begin
      n_fail++; $display("FAIL flush_refetch: got valid %b req %b addr %h expected 0 1 80000180",
                         inst_valid, inst_req, inst_addr);
    end
  endtask

  task automatic test_flush_with_data();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; flush = 1'b1; inst_rdata = 32'hcafe_f00d;
    tick();
    inst_data_ok = 1'b0; flush = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0 || inst_req !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle: got valid %b req %b expected 0 1", inst_valid, inst_req);
    end
    // A clean fetch afterwards must be delivered, proving discard was cleared.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_0abc;
    exp_q.push_back(32'h0000_0abc);
    stall = 1'b1;
    tick();
    inst_data_ok = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] e;
    e = 32'hxxxx_xxxx;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL stall_sb: got empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
    end
    for (int i = 0; i < 4; i++) begin
      stall = 1'b1;
      #1;
      n_tests++;
      if (inst_valid !== 1'b1 || inst_out !== e || inst_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold: got valid %b out %h req %b expected 1 %h 0",
                           inst_valid, inst_out, inst_req, e);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: got valid %b expected 1", inst_valid);
    end
    tick();
    n_tests++;
    if (inst_req !== 1'b1 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_req: got req %b valid %b expected 1 0", inst_req, inst_valid);
    end
  endtask

  task automatic test_flush_on_accept();
    pc = 32'hbfc0_0010; flush = 1'b1; inst_addr_ok = 1'b1;
    tick();
    flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
    #1;
    n_tests++;
    if (inst_addr !== 32'hbfc0_0010 || inst_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_acc_wait: got addr %h req %b expected bfc00010 0", inst_addr, inst_req);
    end
    tick();
    inst_data_ok = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0 || inst_req !== 1'b1) begin
      n_fail++; $display("FAIL flush_acc_drop: got valid %b req %b expected 0 1", inst_valid, inst_req);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] e;
    pc = 32'hbfc0_0002; pc_exp = 1'b1; inst_addr_ok = 1'b1;
    exp_q.push_back(NOP);
    #1;
    n_tests++;
    if (inst_req !== 1'b0) begin
      n_fail++; $display("FAIL mis_req: got %b expected 0", inst_req);
    end
    tick();
    pc_exp = 1'b0; inst_addr_ok = 1'b0; pc = 32'hbfc0_0008;
    #1;
    n_tests++;
    if (exp_q.size() == 0 || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL mis_hold: got valid %b size %0d expected 1 1", inst_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (inst_out !== e) begin
        n_fail++; $display("FAIL mis_data: got %h expected %h", inst_out, e);
      end
    end
    tick();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; rst = 1'b1;
    #1;
    n_tests++;
    if ({inst_req, inst_valid, fetch_stall} !== 3'b001 || inst_addr !== 32'h0 || inst_out !== NOP) begin
      n_fail++; $display("FAIL rst_wait: got %b addr %h out %h expected 001 0 %h",
                         {inst_req, inst_valid, fetch_stall}, inst_addr, inst_out, NOP);
    end
    tick();
    rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_0055;
    #1;
    n_tests++;
    if (inst_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: got req %b valid %b expected 0 0", inst_req, inst_valid);
    end
    tick();
    tick();
    inst_data_ok = 1'b0;
    #1;
    n_tests++;
    if (inst_req !== 1'b1 || inst_valid !== 1'b0 || inst_out !== NOP) begin
      n_fail++; $display("FAIL rst_ignore: got req %b valid %b out %h expected 1 0 %h",
                         inst_req, inst_valid, inst_out, NOP);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_flush_inflight();
    test_flush_with_data();
    test_stall();
    test_flush_on_accept();
    test_misaligned();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
